// File: rtl/program_dumper.sv
// Walks ternary memory from the lowest address up to a latched end address and
// streams each word with its address over a valid/ready handshake.
module program_dumper #(
  parameter int unsigned WORD_SIZE     = 9,
  parameter int unsigned MEM_ADDR_SIZE = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start_dump,
  input  logic [2*MEM_ADDR_SIZE-1:0]   end_addr,
  output logic [2*MEM_ADDR_SIZE-1:0]   mem_addr,
  output logic                         mem_read,
  input  logic [2*WORD_SIZE-1:0]       mem_read_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*WORD_SIZE-1:0]       out_data,
  output logic [2*MEM_ADDR_SIZE-1:0]   out_addr,
  output logic                         dump_complete
);

  localparam int unsigned DW = 2 * WORD_SIZE;
  localparam int unsigned AW = 2 * MEM_ADDR_SIZE;

  localparam logic [1:0] T_NEG  = 2'b10;
  localparam logic [1:0] T_POS  = 2'b01;

  localparam logic [AW-1:0] ADDR_LOW  = {MEM_ADDR_SIZE{T_NEG}};
  localparam logic [AW-1:0] ADDR_HIGH = {MEM_ADDR_SIZE{T_POS}};
  localparam logic [AW-1:0] ADDR_ONE  = AW'(T_POS);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, DONE} state_e;

  function automatic int trit_val(input logic [1:0] t);
    case (t)
      T_POS:   return 1;
      T_NEG:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] trit_enc(input int v);
    if (v > 0)      return T_POS;
    else if (v < 0) return T_NEG;
    else            return 2'b00;
  endfunction

  function automatic logic [DW-1:0] pad_addr(input logic [AW-1:0] a);
    return DW'(a);
  endfunction

  function automatic logic [DW-1:0] ternary_ripple_carry_adder(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    logic [DW-1:0] s;
    int            carry;
    int            sum;
    s     = '0;
    carry = 0;
    for (int unsigned i = 0; i < WORD_SIZE; i++) begin
      sum = trit_val(a[2*i +: 2]) + trit_val(b[2*i +: 2]) + carry;
      if (sum > 1) begin
        sum   = sum - 3;
        carry = 1;
      end else if (sum < -1) begin
        sum   = sum + 3;
        carry = -1;
      end else begin
        carry = 0;
      end
      s[2*i +: 2] = trit_enc(sum);
    end
    return s;
  endfunction

  // The most significant differing trit decides, so later iterations override.
  function automatic logic ternary_less_than_comparator(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    logic lt;
    lt = 1'b0;
    for (int unsigned i = 0; i < WORD_SIZE; i++) begin
      if (trit_val(a[2*i +: 2]) != trit_val(b[2*i +: 2]))
        lt = trit_val(a[2*i +: 2]) < trit_val(b[2*i +: 2]);
    end
    return lt;
  endfunction

  state_e            state_q, state_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [AW-1:0]     end_addr_q, end_addr_d;
  logic              mem_read_q, mem_read_d;
  logic              out_valid_q, out_valid_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic [AW-1:0]     out_addr_q, out_addr_d;
  logic              dump_complete_q, dump_complete_d;
  logic              addr_more;

  // Stopping at the top address as well as at end_addr keeps the increment from wrapping.
  assign addr_more =
      ternary_less_than_comparator(pad_addr(mem_addr_q), pad_addr(end_addr_q)) &&
      ternary_less_than_comparator(pad_addr(mem_addr_q), pad_addr(ADDR_HIGH));

  always_comb begin
    state_d         = state_q;
    mem_addr_d      = mem_addr_q;
    end_addr_d      = end_addr_q;
    mem_read_d      = 1'b0;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_addr_d      = out_addr_q;
    dump_complete_d = dump_complete_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_dump) begin
          end_addr_d      = end_addr;
          mem_addr_d      = ADDR_LOW;
          mem_read_d      = 1'b1;
          dump_complete_d = 1'b0;
          state_d         = READ;
        end
      end
      READ: state_d = CAPTURE;
      CAPTURE: begin
        out_data_d  = mem_read_data;
        out_addr_d  = mem_addr_q;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (addr_more) begin
            mem_addr_d = AW'(ternary_ripple_carry_adder(pad_addr(mem_addr_q),
                                                        pad_addr(ADDR_ONE)));
            mem_read_d = 1'b1;
            state_d    = READ;
          end else begin
            dump_complete_d = 1'b1;
            state_d         = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      mem_addr_q      <= ADDR_LOW;
      end_addr_q      <= ADDR_LOW;
      mem_read_q      <= 1'b0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_addr_q      <= ADDR_LOW;
      dump_complete_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      mem_addr_q      <= mem_addr_d;
      end_addr_q      <= end_addr_d;
      mem_read_q      <= mem_read_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_addr_q      <= out_addr_d;
      dump_complete_q <= dump_complete_d;
    end
  end

  assign mem_addr      = mem_addr_q;
  assign mem_read      = mem_read_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_addr      = out_addr_q;
  assign dump_complete = dump_complete_q;

endmodule

// File: tb/tb_program_dumper.sv
// Bench for program_dumper: behavioural ternary memory plus an integer-indexed
// model of the expected word/address stream.
module tb_program_dumper;

  localparam int WS     = 9;
  localparam int MS     = 4;
  localparam int DW     = 2 * WS;
  localparam int AW     = 2 * MS;
  localparam int NWORDS = 81;
  localparam int OFFS   = 40;

  logic          clock = 1'b0;
  logic          reset;
  logic          start_dump;
  logic [AW-1:0] end_addr;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic [DW-1:0] mem_read_data = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          dump_complete;

  int mem_val [NWORDS];
  int tests = 0;
  int fails = 0;

  program_dumper #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(MS)) dut (
    .clock(clock), .reset(reset), .start_dump(start_dump), .end_addr(end_addr),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_read_data(mem_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .dump_complete(dump_complete)
  );

  always #5 clock = ~clock;

  // Balanced ternary of an integer: -1 -> 2'b10, 0 -> 2'b00, +1 -> 2'b01.
  function automatic logic [DW-1:0] to_bt(input int v);
    logic [DW-1:0] res;
    int r;
    res = '0;
    for (int i = 0; i < WS; i++) begin
      r = ((v % 3) + 3) % 3;
      if (r == 1) begin
        res[2*i +: 2] = 2'b01;
        v = v - 1;
      end else if (r == 2) begin
        res[2*i +: 2] = 2'b10;
        v = v + 1;
      end
      v = v / 3;
    end
    return res;
  endfunction

  function automatic logic [AW-1:0] idx_to_addr(input int k);
    logic [DW-1:0] t;
    t = to_bt(k - OFFS);
    return t[AW-1:0];
  endfunction

  function automatic int addr_to_idx(input logic [AW-1:0] a);
    int v;
    int w;
    v = 0;
    w = 1;
    for (int i = 0; i < MS; i++) begin
      if (a[2*i +: 2] == 2'b01) v = v + w;
      else if (a[2*i +: 2] == 2'b10) v = v - w;
      w = w * 3;
    end
    v = v + OFFS;
    if (v < 0) v = 0;
    if (v >= NWORDS) v = NWORDS - 1;
    return v;
  endfunction

  always @(posedge clock)
    if (mem_read) mem_read_data <= to_bt(mem_val[addr_to_idx(mem_addr)]);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE or DONE.
  task automatic run_dump(input int end_k, input int ready_pct, input int stall_word,
                          input bit noise);
    int idx;
    int reads;
    int cyc;
    int stall;
    logic [DW-1:0] ed;
    logic [AW-1:0] ea;
    idx = 0; reads = 0; cyc = 0; stall = 0;
    start_dump = 1'b1;
    end_addr   = idx_to_addr(end_k);
    @(negedge clock);
    start_dump = 1'b0;
    check("complete_cleared", 64'(dump_complete), 64'd0);
    check("first_read", 64'(mem_read), 64'd1);
    check("first_addr_low", 64'(mem_addr), 64'(idx_to_addr(0)));
    while (!dump_complete && cyc < 2000) begin
      if (mem_read) reads++;
      if (noise) begin
        start_dump = 1'($urandom_range(1));
        end_addr   = AW'($urandom);
      end
      ea = idx_to_addr(idx);
      ed = (idx < NWORDS) ? to_bt(mem_val[idx]) : '0;
      if (out_valid && stall_word == idx && stall < 5) begin
        out_ready = 1'b0;
        stall++;
        check("stall_data", 64'(out_data), 64'(ed));
        check("stall_addr", 64'(out_addr), 64'(ea));
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_no_read", 64'(mem_read), 64'd0);
      end else begin
        out_ready = ($urandom_range(99) < ready_pct);
      end
      if (out_valid && out_ready) begin
        check("word_data", 64'(out_data), 64'(ed));
        check("word_addr", 64'(out_addr), 64'(ea));
        if (ready_pct == 100 && stall_word < 0)
          check("hs_timing", 64'(cyc), 64'(idx * 3 + 2));
        idx++;
      end
      @(negedge clock);
      cyc++;
    end
    start_dump = 1'b0;
    out_ready  = 1'b0;
    check("no_timeout", 64'(cyc < 2000), 64'd1);
    check("word_count", 64'(idx), 64'(end_k + 1));
    check("read_count", 64'(reads), 64'(end_k + 1));
    repeat (3) begin
      check("done_hold", 64'(dump_complete), 64'd1);
      check("done_no_read", 64'(mem_read), 64'd0);
      check("done_no_valid", 64'(out_valid), 64'd0);
      @(negedge clock);
    end
  endtask

  task automatic check_reset_values();
    check("rst_mem_addr", 64'(mem_addr), 64'(idx_to_addr(0)));
    check("rst_mem_read", 64'(mem_read), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'(idx_to_addr(0)));
    check("rst_complete", 64'(dump_complete), 64'd0);
  endtask

  initial begin
    int cyc;
    reset      = 1'b1;
    start_dump = 1'b0;
    end_addr   = '0;
    out_ready  = 1'b0;
    for (int k = 0; k < NWORDS; k++) mem_val[k] = k;
    repeat (3) @(negedge clock);
    check_reset_values();
    reset = 1'b0;
    @(negedge clock);

    run_dump(2, 100, -1, 1'b0);
    run_dump(2, 100, 1, 1'b0);
    run_dump(0, 100, -1, 1'b0);
    run_dump(NWORDS - 1, 100, -1, 1'b0);

    // Reset while the second word is waiting in SEND.
    start_dump = 1'b1;
    end_addr   = idx_to_addr(5);
    @(negedge clock);
    start_dump = 1'b0;
    out_ready  = 1'b1;
    cyc = 0;
    while (!(out_valid && out_addr == idx_to_addr(1)) && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    check("reach_second_word", 64'(cyc < 50), 64'd1);
    reset     = 1'b1;
    out_ready = 1'b0;
    @(negedge clock);
    check_reset_values();
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("abort_no_valid", 64'(out_valid), 64'd0);
      check("abort_no_read", 64'(mem_read), 64'd0);
    end
    out_ready = 1'b0;
    run_dump(3, 100, -1, 1'b0);

    run_dump(4, 70, -1, 1'b1);

    for (int k = 0; k < NWORDS; k++) mem_val[k] = int'($urandom_range(19682)) - 9841;
    for (int n = 0; n < 6; n++)
      run_dump(int'($urandom_range(30)), int'($urandom_range(100, 30)),
               int'($urandom_range(4)) - 1, 1'($urandom_range(1)));
    run_dump(NWORDS - 1, 60, 7, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
